grf_write_arbiter: RTL

//  Shares the single GRF write port between the in-order WB stage and a long-latency unit (LL: MDU/memory).

---
 rtl/grf_write_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single GRF write port between the in-order WB stage and a long-latency result FIFO.
// Also keeps a per-register busy scoreboard that stalls decode and gates LL issue.
module grf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  output logic        iss_ready,
  input  logic        ll_valid,
  input  logic [4:0]  ll_wa,
  input  logic [31:0] ll_wd,
  input  logic [31:0] ll_pc,
  output logic        ll_ready,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_wa,
  output logic        dec_stall,
  output logic        wb_hold,
  output logic        grf_we,
  output logic [4:0]  grf_wa,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic [SW-1:0] starve_cnt;
  logic          wb_hold_q;

  logic       wb_take;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] head_wa;
  logic       pop;
  logic       push;
  logic       issue;

  assign wb_take    = wb_we && (wb_wa != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign head_wa    = fifo_wa[rd_ptr];

  // A head whose destination is $0 still pops; it just never asserts grf_we.
  assign pop       = !reset && !fifo_empty && !wb_take;
  assign ll_ready  = !reset && !fifo_full;
  assign push      = ll_valid && ll_ready;
  assign iss_ready = !reset && (outstanding < DEPTH_C) && !(busy[iss_wa] && (iss_wa != 5'd0));
  assign issue     = iss_valid && iss_ready;

  assign dec_stall = !reset && ((busy[dec_rs] && (dec_rs != 5'd0)) ||
                                (busy[dec_rt] && (dec_rt != 5'd0)) ||
                                (busy[dec_wa] && (dec_wa != 5'd0)));
  assign wb_hold   = wb_hold_q && !reset;

  always_comb begin
    grf_we = 1'b0;
    grf_wa = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (!reset) begin
      if (wb_take) begin
        grf_we = 1'b1;
        grf_wa = wb_wa;
        grf_wd = wb_wd;
        grf_pc = wb_pc;
      end else if (!fifo_empty) begin
        grf_we = (head_wa != 5'd0);
        grf_wa = head_wa;
        grf_wd = fifo_wd[rd_ptr];
        grf_pc = fifo_pc[rd_ptr];
      end
    end
  end

  // Issue and pop never name the same register, so the order of these updates is immaterial.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_wa] = 1'b0;
    if (issue) busy_next[iss_wa] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_wa[i] <= 5'd0;
        fifo_wd[i] <= 32'd0;
        fifo_pc[i] <= 32'd0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      busy        <= 32'd0;
      starve_cnt  <= '0;
      wb_hold_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_wa[wr_ptr] <= ll_wa;
        fifo_wd[wr_ptr] <= ll_wd;
        fifo_pc[wr_ptr] <= ll_pc;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end

      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (issue && !pop) outstanding <= outstanding + 1'b1;
      else if (!issue && pop) outstanding <= outstanding - 1'b1;

      busy <= busy_next;

      // The counter saturates so an ignored wb_hold cannot wrap it back into a fresh hold.
      if (fifo_empty || pop) starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + 1'b1;

      wb_hold_q <= !fifo_empty && !pop && (starve_cnt == LIMIT_M1);
    end
  end

endmodule
